// File: rtl/hsi_mse_pkg.sv
// hsi_mse_pkg -- shared types and default widths for the MSE accumulator.
//   DEF_DATA_WIDTH_SUM : width of one partial squared-difference sum
//   DEF_ACC_WIDTH      : accumulator / result width
//   DEF_CNT_WIDTH      : word-counter width (MAX_WORDS = 2^CNT_WIDTH-1)
//   state_t            : controller states; DIVIDE exists only when
//                        HSI_MSE_MEAN_EN is defined.
package hsi_mse_pkg;

  localparam int DEF_DATA_WIDTH_SUM = 32;
  localparam int DEF_ACC_WIDTH      = 48;
  localparam int DEF_CNT_WIDTH      = 8;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
`ifdef HSI_MSE_MEAN_EN
    DIVIDE = 2'd1,
`endif
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/hsi_mse_acc_if.sv
// hsi_mse_acc_if -- stream bundle between the 4-lane stage, the MSE
// accumulator and the result consumer.
//   data_sum_valid/in/last, data_sum_ready : partial-sum input stream
//   mse_valid/out/words/overflow, mse_ready: result stream
// Modports: master = producer of partial sums and consumer of results,
//           slave  = the accumulator.
interface hsi_mse_acc_if
  import hsi_mse_pkg::*;
#(
  parameter int DATA_WIDTH_SUM = DEF_DATA_WIDTH_SUM,
  parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
);

  logic                      data_sum_valid;
  logic [DATA_WIDTH_SUM-1:0] data_sum_in;
  logic                      data_sum_last;
  logic                      data_sum_ready;
  logic                      mse_valid;
  logic [ACC_WIDTH-1:0]      mse_out;
  logic [CNT_WIDTH-1:0]      mse_words;
  logic                      mse_overflow;
  logic                      mse_ready;

  modport master (
    output data_sum_valid, data_sum_in, data_sum_last, mse_ready,
    input  data_sum_ready, mse_valid, mse_out, mse_words, mse_overflow
  );

  modport slave (
    input  data_sum_valid, data_sum_in, data_sum_last, mse_ready,
    output data_sum_ready, mse_valid, mse_out, mse_words, mse_overflow
  );

endinterface

// File: rtl/hsi_mse_div.sv
// hsi_mse_div -- restoring serial divider, one quotient bit per cycle.
// Only compiled when HSI_MSE_MEAN_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : abort a division in progress
//   start      : load dividend/divisor and begin (ACC_WIDTH iterations)
//   busy       : division in progress
//   done       : final iteration this cycle; quotient valid from next edge
//   quotient   : floor(dividend / divisor), held until the next start
`ifdef HSI_MSE_MEAN_EN
module hsi_mse_div
  import hsi_mse_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int DIV_WIDTH = DEF_CNT_WIDTH + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 start,
  input  logic [ACC_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_WIDTH-1:0] quotient
);

  localparam int                STEP_W    = $clog2(ACC_WIDTH + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ACC_WIDTH - 1);

  logic [DIV_WIDTH-1:0] rem;
  logic [DIV_WIDTH-1:0] dsr;
  logic [STEP_W-1:0]    step;
  logic [DIV_WIDTH:0]   shifted;
  logic [DIV_WIDTH:0]   trial;

  // quotient doubles as the dividend shift register: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  assign shifted = {rem, quotient[ACC_WIDTH-1]};
  // shifted < 2*divisor, so the MSB of the difference is a clean borrow flag.
  assign trial   = shifted - {1'b0, dsr};
  assign done    = busy && (step == LAST_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      step     <= '0;
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
    end else if (clear) begin
      busy <= 1'b0;
      step <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      step     <= '0;
      rem      <= '0;
      dsr      <= divisor;
      quotient <= dividend;
    end else if (busy) begin
      if (trial[DIV_WIDTH]) begin
        rem      <= shifted[DIV_WIDTH-1:0];
        quotient <= {quotient[ACC_WIDTH-2:0], 1'b0};
      end else begin
        rem      <= trial[DIV_WIDTH-1:0];
        quotient <= {quotient[ACC_WIDTH-2:0], 1'b1};
      end
      step <= step + STEP_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/hsi_mse_acc.sv
// hsi_mse_acc -- accumulates partial squared-difference sums of one pixel
// vector and presents the total (or the mean) with a valid/ready handshake.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clear : synchronous abort of the vector in progress
//   bus   : hsi_mse_acc_if.slave (partial-sum input and result output)
// Optional feature: define HSI_MSE_MEAN_EN to divide the saturated sum by
// 4*words with a serial divider (ACC_WIDTH extra cycles of latency).
module hsi_mse_acc
  import hsi_mse_pkg::*;
#(
  parameter int DATA_WIDTH_SUM = DEF_DATA_WIDTH_SUM,
  parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  hsi_mse_acc_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] MAX_WORDS = '1;

  state_t               state;
  state_t               state_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;

  logic                 accept;
  logic                 at_max;
  logic                 last_eff;
  logic                 result_hs;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [ACC_WIDTH:0]   sum_sat;

  // Returns {carry, value}; value is forced to all-ones on carry-out.
  function automatic logic [ACC_WIDTH:0] sat_add(
    input logic [ACC_WIDTH-1:0]      a,
    input logic [DATA_WIDTH_SUM-1:0] b
  );
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + (ACC_WIDTH + 1)'(b);
    if (s[ACC_WIDTH]) s[ACC_WIDTH-1:0] = '1;
    return s;
  endfunction

  assign accept    = bus.data_sum_valid && (state == ACCUM);
  assign cnt_inc   = cnt + CNT_WIDTH'(1);
  // A full counter closes the vector even without data_sum_last.
  assign at_max    = (cnt_inc == MAX_WORDS);
  assign last_eff  = bus.data_sum_last || at_max;
  assign sum_sat   = sat_add(acc, bus.data_sum_in);
  assign result_hs = (state == DONE) && bus.mse_ready;

`ifdef HSI_MSE_MEAN_EN
  logic                 div_busy;
  logic                 div_done;
  logic [ACC_WIDTH-1:0] div_q;

  // The divider captures the sum including the last word straight from the
  // adder, so DIVIDE starts the same edge the last word is accepted.
  hsi_mse_div #(
    .ACC_WIDTH (ACC_WIDTH),
    .DIV_WIDTH (CNT_WIDTH + 2)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .start    (accept && last_eff),
    .dividend (sum_sat[ACC_WIDTH-1:0]),
    .divisor  ({cnt_inc, 2'b00}),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: begin
        if (accept && last_eff) begin
`ifdef HSI_MSE_MEAN_EN
          state_nxt = DIVIDE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef HSI_MSE_MEAN_EN
      DIVIDE: begin
        if (div_done)       state_nxt = DONE;
        // Divider aborted underneath us: nothing valid to present.
        else if (!div_busy) state_nxt = ACCUM;
      end
`endif
      DONE: begin
        if (bus.mse_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
    if (clear) state_nxt = ACCUM;
  end

  // Accumulate stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear || result_hs) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= sum_sat[ACC_WIDTH-1:0];
      cnt <= cnt_inc;
      ovf <= ovf | sum_sat[ACC_WIDTH] | at_max;
    end
  end

  assign bus.data_sum_ready = (state == ACCUM);
  assign bus.mse_valid      = (state == DONE);
  assign bus.mse_words      = cnt;
  assign bus.mse_overflow   = ovf;
`ifdef HSI_MSE_MEAN_EN
  assign bus.mse_out        = div_q;
`else
  assign bus.mse_out        = acc;
`endif

endmodule

// File: tb/tb_hsi_mse_acc.sv
// tb_hsi_mse_acc -- scoreboard bench for hsi_mse_acc (ACC_WIDTH=33 so that
// saturation is reachable with 32-bit words). Expected results are built
// from whole vectors: total = min(sum, 2^33-1), overflow when the sum
// exceeds the accumulator or the vector reaches 255 words; with
// HSI_MSE_MEAN_EN the result is floor(total / (4*words)).
module tb_hsi_mse_acc;

  localparam int DW     = 32;
  localparam int AW     = 33;
  localparam int CW     = 8;
  localparam int HALF   = 5;
  localparam int PERIOD = 10;
  localparam int MAXW   = (1 << CW) - 1;
  localparam logic [63:0] ACC_MAX = (64'd1 << AW) - 64'd1;
`ifdef HSI_MSE_MEAN_EN
  localparam int LAT = AW + 1;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [63:0] out;
    logic [63:0] words;
    logic [63:0] ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  hsi_mse_acc_if #(.DATA_WIDTH_SUM(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  hsi_mse_acc #(.DATA_WIDTH_SUM(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #HALF clk = ~clk;

  int              n_vec = 0;
  int              n_fail = 0;
  exp_t            exp_q[$];
  longint unsigned cur_words[$];
  bit              rand_ready = 1'b0;
  time             hs_time = 0;
  time             acc_time = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endfunction

  // Reference model: collect the words of the vector, score it as a whole.
  function automatic void model_accept(input logic [DW-1:0] w, input bit last);
    longint unsigned sum;
    exp_t e;
    cur_words.push_back(64'(w));
    if (last || cur_words.size() == MAXW) begin
      sum = 0;
      foreach (cur_words[i]) sum += cur_words[i];
      e.ovf   = 64'((sum > ACC_MAX) || (cur_words.size() == MAXW));
      e.out   = (sum > ACC_MAX) ? ACC_MAX : sum;
`ifdef HSI_MSE_MEAN_EN
      e.out   = e.out / 64'(4 * cur_words.size());
`endif
      e.words = 64'(cur_words.size());
      exp_q.push_back(e);
      cur_words.delete();
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the word is taken.
  task automatic send_word(input logic [DW-1:0] w, input bit last);
    int guard;
    guard = 0;
    bus.data_sum_valid = 1'b1;
    bus.data_sum_in    = w;
    bus.data_sum_last  = last;
    @(negedge clk);
    while (!bus.data_sum_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: data_sum_ready got 0, want 1 within 400 cycles");
    end else begin
      @(posedge clk);
      acc_time = $time;
      model_accept(w, last);
    end
    #1;
    bus.data_sum_valid = 1'b0;
    bus.data_sum_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.mse_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic expect_quiet(input int n, input string name);
    int seen;
    seen = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.mse_valid) seen++;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  // One-cycle clear; optionally offers a last word in the same cycle.
  task automatic do_clear(input bit with_word);
    clear = 1'b1;
    if (with_word) begin
      bus.data_sum_valid = 1'b1;
      bus.data_sum_in    = 32'd100;
      bus.data_sum_last  = 1'b1;
    end
    @(posedge clk);
    #1;
    clear              = 1'b0;
    bus.data_sum_valid = 1'b0;
    bus.data_sum_last  = 1'b0;
    cur_words.delete();
    check("clear_valid", 64'(bus.mse_valid), 64'd0);
    check("clear_words", 64'(bus.mse_words), 64'd0);
    check("clear_ready", 64'(bus.data_sum_ready), 64'd1);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(bus.mse_valid), 64'd0);
    check("rst_out", 64'(bus.mse_out), 64'd0);
    check("rst_words", 64'(bus.mse_words), 64'd0);
    check("rst_ovf", 64'(bus.mse_overflow), 64'd0);
    check("rst_ready", 64'(bus.data_sum_ready), 64'd1);
    exp_q.delete();
    cur_words.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every cycle a result is shown it must match the
  // head of the queue; it is popped on the handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mse_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_result: got mse_valid=1 out=0x%0h, want no result", bus.mse_out);
        end else begin
          e = exp_q[0];
          check("mse_out", 64'(bus.mse_out), e.out);
          check("mse_words", 64'(bus.mse_words), e.words);
          check("mse_overflow", 64'(bus.mse_overflow), e.ovf);
          if (bus.mse_ready) begin
            e = exp_q.pop_front();
            hs_time = $time + HALF;
          end
        end
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.mse_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no completion, want summary before 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int len;
    logic [DW-1:0] w;

    rst_n              = 1'b0;
    clear              = 1'b0;
    bus.data_sum_valid = 1'b0;
    bus.data_sum_in    = '0;
    bus.data_sum_last  = 1'b0;
    bus.mse_ready      = 1'b0;

    #12;
    check("init_valid", 64'(bus.mse_valid), 64'd0);
    check("init_out", 64'(bus.mse_out), 64'd0);
    check("init_words", 64'(bus.mse_words), 64'd0);
    check("init_ovf", 64'(bus.mse_overflow), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("init_ready", 64'(bus.data_sum_ready), 64'd1);

    // three words, last on the third
    bus.mse_ready = 1'b1;
    send_word(32'd7, 1'b0);
    send_word(32'd10, 1'b0);
    send_word(32'd3, 1'b1);
    wait_valid(n);
    check("latency_3w", 64'(n), 64'(LAT - 1));
    drain("drain_3w");

    // single word vector
    send_word(32'd7, 1'b1);
    wait_valid(n);
    check("latency_1w", 64'(n), 64'(LAT - 1));
    drain("drain_1w");

    // consumer back-pressure, next vector waits for the handshake
    bus.mse_ready = 1'b0;
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b1);
    wait_valid(n);
    check("latency_stall", 64'(n), 64'(LAT - 1));
    fork
      send_word(32'd5, 1'b1);
      begin
        repeat (5) begin
          check("stall_ready", 64'(bus.data_sum_ready), 64'd0);
          check("stall_valid", 64'(bus.mse_valid), 64'd1);
          @(posedge clk);
          #1;
        end
        bus.mse_ready = 1'b1;
      end
    join
    check("accept_after_hs", 64'(acc_time - hs_time), 64'(PERIOD));
    drain("drain_stall");

    // saturation
    send_word(32'hFFFF_FFFF, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b1);
    drain("drain_sat");

    // clear mid-vector, racing a last word that must be dropped
    send_word(32'd4, 1'b0);
    send_word(32'd9, 1'b0);
    do_clear(1'b1);
    send_word(32'd5, 1'b1);
    drain("drain_clear");

    // reset after two words
    send_word(32'd2, 1'b0);
    send_word(32'd2, 1'b0);
    do_reset();
    bus.mse_ready = 1'b1;
    expect_quiet(5, "quiet_after_rst");
`ifdef HSI_MSE_MEAN_EN
    // reset during the division
    send_word(32'd6, 1'b0);
    send_word(32'd6, 1'b1);
    idle(3);
    do_reset();
    expect_quiet(AW + 5, "quiet_after_div_rst");
`endif
    send_word(32'd2, 1'b0);
    send_word(32'd2, 1'b1);
    drain("drain_rst");

    // word counter reaching its maximum closes the vector
    for (int i = 0; i < MAXW; i++) send_word(32'd1, 1'b0);
    drain("drain_maxw");
    send_word(32'd3, 1'b1);
    drain("drain_after_maxw");

    // randomized vectors with random back-pressure and occasional clears
    rand_ready = 1'b1;
    for (int v = 0; v < 80; v++) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 30))
                                        : int'($urandom_range(1, 6));
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 3))
          0:       w = $urandom_range(0, 255);
          1:       w = $urandom;
          2:       w = 32'hFFFF_FFFF;
          default: w = $urandom_range(0, 65535);
        endcase
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        send_word(w, k == len - 1);
        if (k != len - 1 && $urandom_range(0, 11) == 0) do_clear(1'($urandom_range(0, 1)));
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.mse_ready = 1'b1;
    drain("drain_random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
